led_pwm_driver: RTL
===================

# led_pwm_driver

Output stage of the lighting datapath. It consumes the brightness level (0-15) and the animation enable flag from the hour-based LED controller and drives the board LEDs. In static mode it produces glitch-free PWM on every LED. In animation mode it produces a moving "wave": a full-brightness head with dimmed neighbours.

## Interface
Parameters:
- `NUM_LEDS`, 16: number of driven LEDs; legal range 3..16.
- `PWM_DIV`, 64: system clocks per PWM step; must be ≥ 1.
- `ANIM_DIV`, 25_000_000: system clocks per wave step; must be ≥ 1.

Ports:
- `i_clk`, in, 1: system clock; all logic is on its rising edge.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `i_pwm_value`, in, 4: requested static brightness, 0 = off, 15 = full.
- `i_use_animation`, in, 1: 1 selects wave mode; 0 selects static PWM.
- `o_led`, out, NUM_LEDS: LED drive, registered.
- `o_anim_pos`, out, $clog2(NUM_LEDS): current wave head index, registered, exposed for verification.

## Operation
- **Input register:** `i_pwm_value` and `i_use_animation` are registered every cycle into `r_level` and `r_anim`.
- **PWM step counter:**
  - `r_div` counts 0..PWM_DIV-1.
  - On the terminal count, `r_step` advances 0..14 and wraps 14→0. One PWM period is 15 steps = 15·PWM_DIV cycles.
- **Duty latch:**
  - `r_duty` loads `r_level` only on the step-wrap event (`r_step`=14 and `r_div` terminal).
  - A level change mid-period never alters the current period.
- **Compare:** a channel is on when `r_step < duty`.
  - Duty 0 is always off.
  - Duty 15 is always on.
- **State machine:** `ST_STATIC`, `ST_FWD`, `ST_REV`. `ST_REV` exists only with the configuration macro.
  - **ST_STATIC:** every LED uses the compare with `r_duty`. When `r_anim`=1, go to `ST_FWD`, clear `r_pos` and the animation prescaler.
  - **ST_FWD / ST_REV:**
    - The animation prescaler counts 0..ANIM_DIV-1. On its terminal count, `r_pos` steps.
    - LED[`r_pos`] uses duty 15.
    - LED[`r_pos`±1] use duty 5, only if the index lies within 0..NUM_LEDS-1. Neighbours never wrap.
    - All other LEDs are 0.
    - When `r_anim`=0, go to `ST_STATIC` and clear `r_pos` and the animation prescaler.
  - **Step rule in ST_FWD:**
    - Without macro: `r_pos` = NUM_LEDS-1 wraps to 0.
    - With macro: at NUM_LEDS-1, `r_pos` goes to NUM_LEDS-2 and state goes to `ST_REV`.
  - **Step rule in ST_REV:** `r_pos` decrements. At 0, `r_pos` goes to 1 and state goes to `ST_FWD`.
- **Free-running PWM:** the PWM counters run continuously in all states. Mode changes do not reset them.
- **Arithmetic:** all counters are unsigned. `r_div` is $clog2(PWM_DIV+1) bits. The animation prescaler is $clog2(ANIM_DIV+1) bits. `r_step` is 4 bits.

## Timing
- **Reset values:** on `i_rst_n` low, the following clear immediately and asynchronously:
  - `o_led` = 0 and `o_anim_pos` = 0.
  - State = `ST_STATIC`.
  - `r_div`, `r_step`, `r_duty`, `r_level`, `r_anim` and the animation prescaler = 0.
- **After reset release:** the first PWM period has duty 0. The duty latched at the first wrap applies from the second period.
- **Static level latency:** the input is registered at edge N. It is used from the first period boundary after N. `o_led` reflects the compare one cycle after it is evaluated.
- **Mode latency:**
  - `i_use_animation` is sampled at edge N.
  - State changes at N+1.
  - `o_led` and `o_anim_pos` reflect the new mode at N+2.
- **Simultaneous events:**
  - A wave step and a PWM wrap in the same cycle are both applied.
  - A mode change in the same cycle as a wave step takes precedence: position clears, no step.
- **Reset mid-period or mid-wave:** all state is discarded. No partial pulse completes.

## Configuration
- `LED_WAVE_BOUNCE_EN` defined:
  - `ST_REV` is compiled in.
  - The head ping-pongs 0→NUM_LEDS-1→0, with no repeated endpoint.
- `LED_WAVE_BOUNCE_EN` undefined:
  - Only `ST_STATIC` and `ST_FWD` exist.
  - The head wraps NUM_LEDS-1→0 and moves one direction only.

## Test plan
All scenarios use NUM_LEDS=16, PWM_DIV=2, ANIM_DIV=4. The PWM period is 30 cycles.
- **Reset mid-operation:** run in wave mode with `r_pos`=7, then pulse `i_rst_n` low between clock edges. `o_led`=0 and `o_anim_pos`=0 immediately, and state is `ST_STATIC`.
- **Static duty:** `i_pwm_value`=5, static mode. After two periods, every LED is high for exactly 10 of each 30 cycles, aligned to `r_step`=0.
- **Mid-period change:** change `i_pwm_value` 5→10 at `r_step`=3. The current period keeps 10 high cycles, the next has 20.
- **Extremes:** `i_pwm_value`=0 gives `o_led`=0 for 3 full periods. `i_pwm_value`=15 gives `o_led`=16'hFFFF continuously.
- **Wave stepping:** raise `i_use_animation`.
  - At N+2, `o_anim_pos`=0, LED0 is constantly 1 and LED1 is at 10/30 duty.
  - The position advances every 4 cycles.
  - With the macro, the sequence after 15 is 14, 13, ….
  - Without the macro, the sequence after 15 is 0.
- **Exit animation:** drop `i_use_animation` while `o_anim_pos`=9 and `i_pwm_value`=2. At N+2, `o_anim_pos`=0 and all LEDs follow the static compare against the current `r_duty`. The new level 2 applies from the next period boundary.

Source files
------------

// File: rtl/led_pwm_driver.sv
// LED output stage: glitch-free 15-step PWM in static mode, moving wave in animation mode.
// Define LED_WAVE_BOUNCE_EN to make the wave head ping-pong instead of wrapping.
module led_pwm_driver #(
    parameter int unsigned NUM_LEDS = 16,
    parameter int unsigned PWM_DIV  = 64,
    parameter int unsigned ANIM_DIV = 25_000_000
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [3:0]                  i_pwm_value,
    input  logic                        i_use_animation,
    output logic [NUM_LEDS-1:0]         o_led,
    output logic [$clog2(NUM_LEDS)-1:0] o_anim_pos
);

    localparam int unsigned POS_W = $clog2(NUM_LEDS);
    localparam int unsigned DIV_W = $clog2(PWM_DIV + 1);
    localparam int unsigned PRE_W = $clog2(ANIM_DIV + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PWM_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(ANIM_DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

`ifdef LED_WAVE_BOUNCE_EN
    typedef enum logic [1:0] {ST_STATIC, ST_FWD, ST_REV} state_t;
`else
    typedef enum logic [1:0] {ST_STATIC, ST_FWD} state_t;
`endif

    state_t             r_state;
    logic [3:0]         r_level;
    logic               r_anim;
    logic [DIV_W-1:0]   r_div;
    logic [3:0]         r_step;
    logic [3:0]         r_duty;
    logic [POS_W-1:0]   r_pos;
    logic [PRE_W-1:0]   r_pre;

    logic               div_tc;
    logic               step_wrap;
    logic               pre_tc;
    int                 pos_i;
    logic [3:0]         sel_duty;
    logic [NUM_LEDS-1:0] led_next;

    assign div_tc    = (r_div == DIV_LAST);
    assign step_wrap = div_tc && (r_step == 4'd14);
    assign pre_tc    = (r_pre == PRE_LAST);

    // PWM timebase runs in every state so mode changes never disturb the period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level <= 4'd0;
            r_anim  <= 1'b0;
            r_div   <= '0;
            r_step  <= 4'd0;
            r_duty  <= 4'd0;
        end else begin
            r_level <= i_pwm_value;
            r_anim  <= i_use_animation;
            if (div_tc) begin
                r_div  <= '0;
                r_step <= (r_step == 4'd14) ? 4'd0 : r_step + 4'd1;
            end else begin
                r_div <= r_div + 1'b1;
            end
            if (step_wrap) begin
                r_duty <= r_level;
            end
        end
    end

    // Neighbour indices are compared as signed ints so pos-1 at 0 never matches.
    always_comb begin
        led_next = '0;
        sel_duty = 4'd0;
        pos_i    = int'(r_pos);
        for (int i = 0; i < int'(NUM_LEDS); i++) begin
            if (r_state == ST_STATIC) begin
                sel_duty = r_duty;
            end else if (i == pos_i) begin
                sel_duty = 4'd15;
            end else if ((i == pos_i + 1) || (i == pos_i - 1)) begin
                sel_duty = 4'd5;
            end else begin
                sel_duty = 4'd0;
            end
            led_next[i] = (r_step < sel_duty);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_STATIC;
            r_pos      <= '0;
            r_pre      <= '0;
            o_led      <= '0;
            o_anim_pos <= '0;
        end else begin
            o_led      <= led_next;
            o_anim_pos <= r_pos;
            case (r_state)
                ST_STATIC: begin
                    if (r_anim) begin
                        r_state <= ST_FWD;
                        r_pos   <= '0;
                        r_pre   <= '0;
                    end
                end
                ST_FWD: begin
                    if (!r_anim) begin
                        r_state <= ST_STATIC;
                        r_pos   <= '0;
                        r_pre   <= '0;
                    end else if (pre_tc) begin
                        r_pre <= '0;
`ifdef LED_WAVE_BOUNCE_EN
                        if (r_pos == POS_LAST) begin
                            r_pos   <= POS_LAST - 1'b1;
                            r_state <= ST_REV;
                        end else begin
                            r_pos <= r_pos + 1'b1;
                        end
`else
                        r_pos <= (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
`endif
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                end
`ifdef LED_WAVE_BOUNCE_EN
                ST_REV: begin
                    if (!r_anim) begin
                        r_state <= ST_STATIC;
                        r_pos   <= '0;
                        r_pre   <= '0;
                    end else if (pre_tc) begin
                        r_pre <= '0;
                        if (r_pos == '0) begin
                            r_pos   <= POS_W'(1);
                            r_state <= ST_FWD;
                        end else begin
                            r_pos <= r_pos - 1'b1;
                        end
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= ST_STATIC;
                    r_pos   <= '0;
                    r_pre   <= '0;
                end
            endcase
        end
    end

endmodule
